fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 27 ++
 rtl/fetch_ctrl_if.sv | 21 ++
 rtl/fetch_ctrl_npc_mux.sv | 24 ++
 rtl/fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: FSM encoding, NOP word, pcsrc codes, IF/ID layout.
package fetch_ctrl_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t StBoot    = 2'd0;
  localparam fsm_state_t StRun     = 2'd1;
  localparam fsm_state_t StMemWait = 2'd2;

  localparam logic [31:0] Nop = 32'h0000_0013;

  localparam logic [1:0] PcsrcSeq = 2'b00;
  localparam logic [1:0] PcsrcBr  = 2'b01;
  localparam logic [1:0] PcsrcJmp = 2'b10;
  localparam logic [1:0] PcsrcReg = 2'b11;

  typedef struct packed {
    logic [31:0] dpc4;
    logic [31:0] dinst;
    logic        dvalid;
  } ifid_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and instruction memory (slave).
interface fetch_ctrl_if;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output pc,
    output imem_req,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  pc,
    input  imem_req,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_ctrl_npc_mux.sv
// Next-PC selector: purely combinational choice among sequential, branch, jump and register targets.
module npc_mux
  import fetch_ctrl_pkg::*;
(
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] bpc_i,
  input  logic [31:0] jpc_i,
  input  logic [31:0] rpc_i,
  output logic [31:0] npc_o
);

  always_comb begin
    npc_o = pc4_i;
    unique case (pcsrc_i)
      PcsrcSeq: npc_o = pc4_i;
      PcsrcBr:  npc_o = bpc_i;
      PcsrcJmp: npc_o = jpc_i;
      PcsrcReg: npc_o = rpc_i;
      default:  npc_o = pc4_i;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller with IF/ID register and deferred redirect.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wpcir,
  input  logic               flush,
  input  logic [1:0]         pcsrc,
  input  logic [31:0]        bpc,
  input  logic [31:0]        jpc,
  input  logic [31:0]        rpc,
  fetch_ctrl_if.master       imem,
  output logic [31:0]        dpc4,
  output logic [31:0]        dinst,
  output logic               dvalid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt,
  output logic [31:0]        memwait_cnt
`endif
);

  fsm_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  ifid_t       ifid_q, ifid_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  logic        active;
  logic        adv;
  logic [31:0] pc4;
  logic [31:0] npc;

  assign active = (state_q == StRun) || (state_q == StMemWait);
  assign adv    = active && imem.imem_valid && wpcir;
  assign pc4    = pc_q + 32'd4;

  npc_mux u_npc_mux (
    .pcsrc_i (pcsrc),
    .pc4_i   (pc4),
    .bpc_i   (bpc),
    .jpc_i   (jpc),
    .rpc_i   (rpc),
    .npc_o   (npc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;

    case (state_q)
      StBoot:    state_d = StRun;
      StRun:     if (!imem.imem_valid) state_d = StMemWait;
      StMemWait: if (imem.imem_valid) state_d = StRun;
      default:   state_d = StBoot;
    endcase

    if (adv) begin
      if (redir_pend_q) begin
        // Word fetched from the stale path is dropped.
        pc_d         = redir_pc_q;
        redir_pend_d = 1'b0;
        ifid_d       = '{dpc4: ifid_q.dpc4, dinst: Nop, dvalid: 1'b0};
      end else begin
        pc_d   = npc;
        ifid_d = '{dpc4: pc4, dinst: imem.imem_rdata, dvalid: 1'b1};
      end
    end else if (active) begin
      if ((pcsrc != PcsrcSeq) && !redir_pend_q) begin
        redir_pend_d = 1'b1;
        redir_pc_d   = npc;
      end
      if (!imem.imem_valid && wpcir) begin
        ifid_d = '{dpc4: ifid_q.dpc4, dinst: Nop, dvalid: 1'b0};
      end
    end

    if (flush) begin
      ifid_d.dinst  = Nop;
      ifid_d.dvalid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      ifid_q       <= '{dpc4: 32'd0, dinst: Nop, dvalid: 1'b0};
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  assign imem.pc       = pc_q;
  assign imem.imem_req = active;
  assign dpc4          = ifid_q.dpc4;
  assign dinst         = ifid_q.dinst;
  assign dvalid        = ifid_q.dvalid;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] memwait_cnt_q, memwait_cnt_d;

  always_comb begin
    stall_cnt_d   = (active && !wpcir) ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d   = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    memwait_cnt_d = (state_q == StMemWait) ? sat_inc(memwait_cnt_q) : memwait_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= 32'd0;
      flush_cnt_q   <= 32'd0;
      memwait_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign memwait_cnt = memwait_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed scoreboard bench for fetch_ctrl: each step pushes hand-derived expectations, popped after the edge.
module tb_fetch_ctrl;

  localparam logic [31:0] NopW = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        wpcir;
  logic        flush;
  logic [1:0]  pcsrc;
  logic [31:0] bpc, jpc, rpc;
  logic [31:0] dpc4, dinst;
  logic        dvalid;
`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;
`endif

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wpcir  (wpcir),
    .flush  (flush),
    .pcsrc  (pcsrc),
    .bpc    (bpc),
    .jpc    (jpc),
    .rpc    (rpc),
    .imem   (imem_bus),
    .dpc4   (dpc4),
    .dinst  (dinst),
    .dvalid (dvalid)
`ifdef FETCH_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .memwait_cnt (memwait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic        chk_dpc4;
    logic [31:0] dinst;
    logic        dvalid;
    logic        req;
    logic        rp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   row   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic wp, input logic fl, input logic [1:0] ps,
                      input logic [31:0] tgt, input logic vld, input logic [31:0] rd,
                      input logic [31:0] e_pc, input logic [31:0] e_dpc4, input logic chk_d,
                      input logic [31:0] e_inst, input logic e_dv, input logic e_req,
                      input logic e_rp);
    exp_t e;
    exp_t o;
    rst   = r;
    wpcir = wp;
    flush = fl;
    pcsrc = ps;
    bpc   = (ps == 2'b01) ? tgt : 32'hBAD0_0001;
    jpc   = (ps == 2'b10) ? tgt : 32'hBAD0_0002;
    rpc   = (ps == 2'b11) ? tgt : 32'hBAD0_0003;
    imem_bus.imem_valid = vld;
    imem_bus.imem_rdata = rd;
    e = '{pc: e_pc, dpc4: e_dpc4, chk_dpc4: chk_d, dinst: e_inst, dvalid: e_dv,
          req: e_req, rp: e_rp};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_eq($sformatf("r%0d pc", row), imem_bus.pc, o.pc);
    if (o.chk_dpc4) check_eq($sformatf("r%0d dpc4", row), dpc4, o.dpc4);
    check_eq($sformatf("r%0d dinst", row), dinst, o.dinst);
    check_eq($sformatf("r%0d dvalid", row), {31'd0, dvalid}, {31'd0, o.dvalid});
    check_eq($sformatf("r%0d imem_req", row), {31'd0, imem_bus.imem_req}, {31'd0, o.req});
    check_eq($sformatf("r%0d redir_pend", row), {31'd0, dut.redir_pend_q}, {31'd0, o.rp});
    row++;
  endtask

  initial begin
    rst = 1'b1; wpcir = 1'b1; flush = 1'b0; pcsrc = 2'b00;
    bpc = '0; jpc = '0; rpc = '0;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_rdata = '0;
    @(posedge clk);
    #1;
    //   rst wp fl ps  tgt            vld rdata          pc             dpc4        chk inst        dv req rp
    step(1, 1, 0, 0, 32'h0,         1, 32'hA000_0000, 32'h0,         32'h0,     1, NopW,         0, 0, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0000, 32'h0,         32'h0,     1, NopW,         0, 1, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0000, 32'h4,         32'h4,     1, 32'hA000_0000, 1, 1, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0001, 32'h8,         32'h8,     1, 32'hA000_0001, 1, 1, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0002, 32'hC,         32'hC,     1, 32'hA000_0002, 1, 1, 0);
    step(0, 0, 0, 0, 32'h0,         1, 32'hA000_0003, 32'hC,         32'hC,     1, 32'hA000_0002, 1, 1, 0);
    step(0, 0, 0, 0, 32'h0,         1, 32'hA000_0003, 32'hC,         32'hC,     1, 32'hA000_0002, 1, 1, 0);
`ifdef FETCH_PERF_EN
    check_eq("stall_cnt_2", stall_cnt, 32'd2);
`endif
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0003, 32'h10,        32'h10,    1, 32'hA000_0003, 1, 1, 0);
    // Immediate jump redirect to pc=8
    step(0, 1, 0, 2, 32'h8,         1, 32'hA000_0004, 32'h8,         32'h14,    1, 32'hA000_0004, 1, 1, 0);
    step(0, 0, 1, 0, 32'h0,         1, 32'hA000_0005, 32'h8,         32'h0,     0, NopW,         0, 1, 0);
    step(0, 1, 1, 0, 32'h0,         1, 32'hA000_0005, 32'hC,         32'h0,     0, NopW,         0, 1, 0);
`ifdef FETCH_PERF_EN
    check_eq("flush_cnt_2", flush_cnt, 32'd2);
    check_eq("stall_cnt_3", stall_cnt, 32'd3);
`endif
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0006, 32'h10,        32'h10,    1, 32'hA000_0006, 1, 1, 0);
    // Branch arrives while memory is not ready: deferred
    step(0, 1, 0, 1, 32'h100,       0, 32'h0,         32'h10,        32'h0,     0, NopW,         0, 1, 1);
    step(0, 1, 0, 0, 32'h0,         0, 32'h0,         32'h10,        32'h0,     0, NopW,         0, 1, 1);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0007, 32'h100,       32'h0,     0, NopW,         0, 1, 0);
`ifdef FETCH_PERF_EN
    check_eq("memwait_cnt_2", memwait_cnt, 32'd2);
`endif
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_0008, 32'h104,       32'h104,   1, 32'hA000_0008, 1, 1, 0);
    // Address wrap at the top of memory
    step(0, 1, 0, 2, 32'hFFFF_FFFC, 1, 32'hA000_0009, 32'hFFFF_FFFC, 32'h108,   1, 32'hA000_0009, 1, 1, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_000A, 32'h0,         32'h0,     1, 32'hA000_000A, 1, 1, 0);
    // Two redirects while stalled: the first one wins
    step(0, 0, 0, 1, 32'h200,       1, 32'hA000_000B, 32'h0,         32'h0,     1, 32'hA000_000A, 1, 1, 1);
    step(0, 0, 0, 2, 32'h300,       1, 32'hA000_000B, 32'h0,         32'h0,     1, 32'hA000_000A, 1, 1, 1);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_000B, 32'h200,       32'h0,     0, NopW,         0, 1, 0);
    // Reset in MEMWAIT with a pending redirect
    step(0, 1, 0, 3, 32'h400,       0, 32'h0,         32'h200,       32'h0,     0, NopW,         0, 1, 1);
    step(1, 1, 0, 3, 32'h400,       0, 32'h0,         32'h0,         32'h0,     1, NopW,         0, 0, 0);
`ifdef FETCH_PERF_EN
    check_eq("stall_cnt_rst", stall_cnt, 32'd0);
    check_eq("flush_cnt_rst", flush_cnt, 32'd0);
    check_eq("memwait_cnt_rst", memwait_cnt, 32'd0);
`endif
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_000C, 32'h0,         32'h0,     1, NopW,         0, 1, 0);
    step(0, 1, 0, 0, 32'h0,         1, 32'hA000_000C, 32'h4,         32'h4,     1, 32'hA000_000C, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
